// File: rtl/fifo_pkg.sv
// Shared defaults and read-mode encodings for the synchronous FIFO family.
package fifo_pkg;

  typedef enum int {
    FIFO_STD  = 0,
    FIFO_FWFT = 1
  } fifo_mode_e;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_FIFO_DEPTH    = 8;
  localparam int DEF_ADRESS_SIZE   = 3;
  localparam int DEF_AFULL_THRESH  = 6;
  localparam int DEF_AEMPTY_THRESH = 1;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array, synchronous write, asynchronous read, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int data_width  = DEF_DATA_WIDTH,
  parameter int adress_size = DEF_ADRESS_SIZE
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [adress_size-1:0] waddr,
  input  logic [data_width-1:0]  wdata,
  input  logic [adress_size-1:0] raddr,
  output logic [data_width-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << adress_size;

  logic [data_width-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with standard or first-word-fall-through read,
// occupancy flags and one-cycle overflow/underflow pulses.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int data_width    = DEF_DATA_WIDTH,
  parameter int fifo_depth    = DEF_FIFO_DEPTH,
  parameter int adress_size   = DEF_ADRESS_SIZE,
  parameter int afull_thresh  = DEF_AFULL_THRESH,
  parameter int aempty_thresh = DEF_AEMPTY_THRESH,
  parameter int fwft          = FIFO_STD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [data_width-1:0]  wdata,
  input  logic                   rd,
  output logic [data_width-1:0]  rdata,
  output logic                   valid,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [adress_size:0]   count,
  output logic                   overflow,
  output logic                   underflow
);

  if (fifo_depth != (1 << adress_size) || fifo_depth < 2 ||
      (fwft != FIFO_STD && fwft != FIFO_FWFT)) begin : g_bad_params
    $error("param_sync_fifo: fifo_depth must be 2**adress_size (>=2) and fwft 0 or 1");
  end

  logic [adress_size:0]    wr_ptr;
  logic [adress_size:0]    rd_ptr;
  logic                    wr_ok;
  logic                    rd_ok;
  logic [data_width-1:0]   mem_rdata;

  // Flags decode straight from the registered pointers, so they trail the edge.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[adress_size] != rd_ptr[adress_size]) &&
                 (wr_ptr[adress_size-1:0] == rd_ptr[adress_size-1:0]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (int'(count) >= afull_thresh);
  assign almost_empty = (int'(count) <= aempty_thresh);

  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + (adress_size+1)'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + (adress_size+1)'(1);
      end
      overflow  <= wr && full;
      underflow <= rd && empty;
    end
  end

  fifo_mem #(
    .data_width (data_width),
    .adress_size(adress_size)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok && !rst),
    .waddr(wr_ptr[adress_size-1:0]),
    .wdata(wdata),
    .raddr(rd_ptr[adress_size-1:0]),
    .rdata(mem_rdata)
  );

  if (fwft == FIFO_FWFT) begin : g_fwft
    // Masked while empty so stale (unreset) memory never shows after reset.
    assign valid = !empty;
    assign rdata = empty ? '0 : mem_rdata;
  end else begin : g_std
    logic [data_width-1:0] rdata_q;
    logic                  valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) begin
          rdata_q <= mem_rdata;
        end
      end
    end

    assign rdata = rdata_q;
    assign valid = valid_q;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: standard and FWFT instances share stimulus and a queue model.
module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr  = 1'b0;
  logic          rd  = 1'b0;
  logic [DW-1:0] wdata = '0;

  logic [DW-1:0] s_rdata, f_rdata;
  logic          s_valid, s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
  logic          f_valid, f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
  logic [AW:0]   s_count, f_count;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue plus the registered read/pulse outputs.
  logic [DW-1:0] q[$];
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  always #5 clk = ~clk;

  param_sync_fifo #(
    .data_width(DW), .fifo_depth(DEPTH), .adress_size(AW),
    .afull_thresh(6), .aempty_thresh(1), .fwft(0)
  ) u_std (
    .clk(clk), .rst(rst), .wr(wr), .wdata(wdata), .rd(rd),
    .rdata(s_rdata), .valid(s_valid), .empty(s_empty), .full(s_full),
    .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf)
  );

  param_sync_fifo #(
    .data_width(DW), .fifo_depth(DEPTH), .adress_size(AW),
    .afull_thresh(6), .aempty_thresh(1), .fwft(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr(wr), .wdata(wdata), .rd(rd),
    .rdata(f_rdata), .valid(f_valid), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  // Advance one clock, update the model from the inputs seen at that edge.
  task automatic step();
    bit do_wr, do_rd;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_valid = 1'b0;
      m_rdata = '0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      m_ovf = wr && (q.size() == DEPTH);
      m_udf = rd && (q.size() == 0);
      do_rd = rd && (q.size() != 0);
      do_wr = wr && (q.size() != DEPTH);
      m_valid = do_rd;
      if (do_rd) m_rdata = q.pop_front();
      if (do_wr) q.push_back(wdata);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    step();
    rst = 1'b0;
    checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", s_count); end
    checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b expected 1", s_empty); end
    checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b expected 0", s_full); end
    checks++; if (s_ae !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b expected 1", s_ae); end
    checks++; if (s_af !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b expected 0", s_af); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", s_valid); end
    checks++; if (s_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %0h expected 0", s_rdata); end
    checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b expected 00", s_ovf, s_udf); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_fwft_valid got %b expected 0", f_valid); end
    checks++; if (f_rdata !== 8'h00) begin errors++; $display("FAIL reset_fwft_rdata got %0h expected 0", f_rdata); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr = 1'b1; wdata = 8'(i);
      step();
      checks++; if (s_count !== 4'(i)) begin errors++; $display("FAIL fill_count got %0d expected %0d", s_count, i); end
      checks++; if (s_af !== (i >= 6)) begin errors++; $display("FAIL fill_almost_full got %b expected %b", s_af, (i >= 6)); end
      checks++; if (s_full !== (i == 8)) begin errors++; $display("FAIL fill_full got %b expected %b", s_full, (i == 8)); end
    end
    wdata = 8'hEE;
    step();
    wr = 1'b0;
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b expected 1", s_ovf); end
    checks++; if (s_count !== 4'd8) begin errors++; $display("FAIL fill_count_after_ovf got %0d expected 8", s_count); end
    step();
    checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL fill_overflow_single got %b expected 0", s_ovf); end
    checks++; if (f_valid !== 1'b1 || f_rdata !== 8'h01) begin errors++; $display("FAIL fill_fwft_head got %b/%0h expected 1/1", f_valid, f_rdata); end
  endtask

  task automatic test_drain();
    rd = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (s_valid !== 1'b1 || s_rdata !== 8'(i)) begin errors++; $display("FAIL drain_data got %b/%0h expected 1/%0h", s_valid, s_rdata, i); end
    end
    checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b expected 1", s_empty); end
    step();
    rd = 1'b0;
    checks++; if (s_udf !== 1'b1) begin errors++; $display("FAIL drain_underflow got %b expected 1", s_udf); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_after got %b expected 0", s_valid); end
    checks++; if (s_rdata !== 8'h08) begin errors++; $display("FAIL drain_rdata_hold got %0h expected 8", s_rdata); end
    step();
    checks++; if (s_udf !== 1'b0) begin errors++; $display("FAIL drain_underflow_single got %b expected 0", s_udf); end
  endtask

  task automatic test_simultaneous();
    wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wdata = 8'($urandom);
      step();
    end
    rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wdata = 8'($urandom);
      step();
      checks++; if (s_count !== 4'd4) begin errors++; $display("FAIL simul_count got %0d expected 4", s_count); end
      checks++; if (s_valid !== 1'b1 || s_rdata !== m_rdata) begin errors++; $display("FAIL simul_data got %b/%0h expected 1/%0h", s_valid, s_rdata, m_rdata); end
      checks++; if (f_rdata !== q[0]) begin errors++; $display("FAIL simul_fwft_head got %0h expected %0h", f_rdata, q[0]); end
    end
    wr = 1'b0;
    while (q.size() != 0) step();
    rd = 1'b0;
  endtask

  task automatic test_boundaries();
    wr = 1'b1;
    while (q.size() < DEPTH) begin
      wdata = 8'($urandom);
      step();
    end
    rd = 1'b1; wdata = 8'h5A;
    step();
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL bound_full_overflow got %b expected 1", s_ovf); end
    checks++; if (s_count !== 4'd7) begin errors++; $display("FAIL bound_full_count got %0d expected 7", s_count); end
    checks++; if (s_valid !== 1'b1 || s_rdata !== m_rdata) begin errors++; $display("FAIL bound_full_read got %b/%0h expected 1/%0h", s_valid, s_rdata, m_rdata); end
    wr = 1'b0;
    while (q.size() != 0) step();
    wr = 1'b1; wdata = 8'h3C;
    step();
    checks++; if (s_udf !== 1'b1) begin errors++; $display("FAIL bound_empty_underflow got %b expected 1", s_udf); end
    checks++; if (s_count !== 4'd1) begin errors++; $display("FAIL bound_empty_count got %0d expected 1", s_count); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bound_empty_valid got %b expected 0", s_valid); end
    wr = 1'b0;
    step();
    checks++; if (s_rdata !== 8'h3C || s_empty !== 1'b1) begin errors++; $display("FAIL bound_empty_write_kept got %0h/%b expected 3c/1", s_rdata, s_empty); end
    rd = 1'b0;
  endtask

  task automatic test_fwft();
    rst = 1'b1;
    step();
    rst = 1'b0; wr = 1'b1; wdata = 8'hA5;
    step();
    wr = 1'b0;
    checks++; if (f_rdata !== 8'hA5 || f_valid !== 1'b1) begin errors++; $display("FAIL fwft_present got %0h/%b expected a5/1", f_rdata, f_valid); end
    step();
    checks++; if (f_rdata !== 8'hA5 || f_valid !== 1'b1) begin errors++; $display("FAIL fwft_hold got %0h/%b expected a5/1", f_rdata, f_valid); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL fwft_std_no_valid got %b expected 0", s_valid); end
    rd = 1'b1;
    step();
    rd = 1'b0;
    checks++; if (f_empty !== 1'b1 || f_valid !== 1'b0) begin errors++; $display("FAIL fwft_pop got %b/%b expected empty 1 valid 0", f_empty, f_valid); end
  endtask

  task automatic test_mid_reset();
    wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata = 8'($urandom_range(1, 255));
      step();
    end
    rd = 1'b1; wdata = 8'($urandom_range(1, 255));
    step();
    checks++; if (s_count !== 4'd6 || s_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %0d/%b expected 6/1", s_count, s_valid); end
    wr = 1'b0;
    step();
    checks++; if (s_count !== 4'd5) begin errors++; $display("FAIL midrst_count5 got %0d expected 5", s_count); end
    rst = 1'b1; wr = 1'b1; rd = 1'b1;
    step();
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    checks++; if (s_count !== 4'd0 || s_empty !== 1'b1) begin errors++; $display("FAIL midrst_state got %0d/%b expected 0/1", s_count, s_empty); end
    checks++; if (s_valid !== 1'b0 || s_rdata !== 8'h00) begin errors++; $display("FAIL midrst_read got %b/%0h expected 0/0", s_valid, s_rdata); end
    checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin errors++; $display("FAIL midrst_pulses got %b%b expected 00", s_ovf, s_udf); end
    checks++; if (f_valid !== 1'b0 || f_rdata !== 8'h00) begin errors++; $display("FAIL midrst_fwft got %b/%0h expected 0/0", f_valid, f_rdata); end
    step();
    checks++; if (s_count !== 4'd0 || s_udf !== 1'b0) begin errors++; $display("FAIL midrst_discard got %0d/%b expected 0/0", s_count, s_udf); end
  endtask

  task automatic test_random();
    int n, bias;
    for (int i = 0; i < 400; i++) begin
      bias  = ((i / 100) % 2 == 0) ? 70 : 30;
      wr    = ($urandom_range(0, 99) < bias);
      rd    = ($urandom_range(0, 99) < (100 - bias));
      rst   = ($urandom_range(0, 59) == 0);
      wdata = 8'($urandom);
      step();
      n = q.size();
      checks++; if (s_count !== 4'(n) || f_count !== 4'(n)) begin errors++; $display("FAIL rand_count got %0d/%0d expected %0d", s_count, f_count, n); end
      checks++; if (s_empty !== (n == 0) || s_full !== (n == DEPTH)) begin errors++; $display("FAIL rand_empty_full got %b%b expected %b%b", s_empty, s_full, (n == 0), (n == DEPTH)); end
      checks++; if (s_ae !== (n <= 1) || s_af !== (n >= 6)) begin errors++; $display("FAIL rand_almost got %b%b expected %b%b", s_ae, s_af, (n <= 1), (n >= 6)); end
      checks++; if (s_ovf !== m_ovf || s_udf !== m_udf) begin errors++; $display("FAIL rand_pulses got %b%b expected %b%b", s_ovf, s_udf, m_ovf, m_udf); end
      checks++; if (s_valid !== m_valid || s_rdata !== m_rdata) begin errors++; $display("FAIL rand_std_read got %b/%0h expected %b/%0h", s_valid, s_rdata, m_valid, m_rdata); end
      checks++; if (f_valid !== (n != 0) || f_rdata !== ((n != 0) ? q[0] : 8'h00)) begin errors++; $display("FAIL rand_fwft_read got %b/%0h expected %b/%0h", f_valid, f_rdata, (n != 0), (n != 0) ? q[0] : 8'h00); end
    end
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_boundaries();
    test_fwft();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
